rip_fetch: RTL and testbench

- Instruction-fetch stage: owns the architectural fetch PC and drives the shared memory's instruction port (fetch address, fetch enable).
- Consumes the 1-cycle-latency instruction word returned by that port and hands decode an {inst, pc, valid} bundle.
- Handles pipeline stall, branch/jump redirect, misaligned-target fault, and counts instructions delivered to decode.

---
 rtl/rip_fetch_pkg.sv | 19 +
 rtl/rip_fetch.sv | 73 +++++++
 tb/tb_rip_fetch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rip_fetch_pkg.sv
// Shared types and constants for the rip instruction-fetch stage.
package rip_const;

  localparam logic [31:0] RIP_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] RIP_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } fetch_bundle_t;

endpackage

// File: rtl/rip_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the memory instruction port
// and presents {inst, pc, valid} to decode with stall, redirect and fault handling.
module rip_fetch
  import rip_const::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RIP_RESET_PC),
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(RIP_NOP_INST)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] mem_pc,
  output logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic                  id_valid,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc,
  output logic [31:0]           fetch_count
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] f_pc;

  assign mem_pc    = f_pc;
  assign mem_ready = (state == RUN) && !stall;
  // The memory output register is the only buffer, so the word is read straight through.
  assign id_inst   = id_valid ? mem_rdata : NOP_INST;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= BOOT;
      f_pc        <= RESET_PC;
      id_pc       <= '0;
      id_valid    <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (id_valid && !stall) begin
        fetch_count <= fetch_count + 32'd1;
      end
      unique case (state)
        BOOT: state <= RUN;
        RUN, FAULT: begin
          // Redirect wins over stall and squashes whatever word is in flight.
          if (redirect) begin
            id_valid <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
              f_pc  <= redirect_pc;
              fault <= 1'b0;
              state <= RUN;
            end else begin
              fault    <= 1'b1;
              fault_pc <= redirect_pc;
              state    <= FAULT;
            end
          end else if (state == RUN && !stall) begin
            f_pc     <= f_pc + DATA_WIDTH'(4);
            id_pc    <= f_pc;
            id_valid <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_fetch.sv
// Randomised scoreboard bench for rip_fetch with a transaction-level stream model.
module tb_rip_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_pc;
  logic        mem_ready;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  rip_fetch dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_pc     (mem_pc),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory: 1-cycle registered read, holds its output while fetch is disabled.
  always @(posedge clk) begin
    if (mem_ready) mem_rdata <= word_at(mem_pc);
  end

  typedef struct {
    bit          chk;
    bit          boot;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          mready;
    logic [31:0] mpc;
    logic [31:0] count;
    bit          flt;
    logic [31:0] flt_pc;
  } exp_t;

  exp_t exp_q[$];

  // Stream model: the bundle stream runs T, T+4, ... from the last restart point
  // and becomes visible after a fixed number of unstalled cycles.
  bit          m_boot;
  bit          m_fault;
  int          m_lat;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [31:0] m_fault_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r_n, input bit st, input bit rd, input logic [31:0] rpc);
    exp_t e;
    @(posedge clk);
    #1;
    rstn        = r_n;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    e.chk    = 1'b1;
    e.boot   = m_boot;
    e.valid  = !m_boot && !m_fault && (m_lat == 0);
    e.pc     = m_pc;
    e.inst   = word_at(m_pc);
    e.mready = !m_boot && !m_fault && !st;
    e.mpc    = (m_lat == 0) ? m_pc + 32'd4 : m_pc;
    e.count  = m_count;
    e.flt    = m_fault;
    e.flt_pc = m_fault_pc;
    exp_q.push_back(e);
    if (!r_n) begin
      m_boot = 1; m_fault = 0; m_lat = 1; m_pc = 32'h0; m_count = 0; m_fault_pc = 0;
    end else begin
      if (e.valid && !st) m_count++;
      if (m_boot) begin
        m_boot = 0;
        m_lat  = 1;
      end else if (rd) begin
        if (rpc[1:0] == 2'b00) begin
          m_pc = rpc; m_lat = 1; m_fault = 0;
        end else begin
          m_fault = 1; m_fault_pc = rpc;
        end
      end else if (!m_fault && !st) begin
        if (m_lat == 0) m_pc = m_pc + 32'd4;
        else m_lat = 0;
      end
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        // A cycle that begins with rstn low still shows pre-reset state.
        if (e.chk && rstn) begin
          check("id_valid", {31'b0, id_valid}, {31'b0, e.valid});
          check("mem_ready", {31'b0, mem_ready}, {31'b0, e.mready});
          check("fetch_count", fetch_count, e.count);
          check("fault", {31'b0, fault}, {31'b0, e.flt});
          check("fault_pc", fault_pc, e.flt_pc);
          if (e.mready) check("mem_pc", mem_pc, e.mpc);
          if (e.valid) begin
            check("id_pc", id_pc, e.pc);
            check("id_inst", id_inst, e.inst);
          end else begin
            check("id_inst_nop", id_inst, 32'h0000_0013);
          end
          if (e.boot) begin
            check("boot_id_pc", id_pc, 32'h0);
            check("boot_mem_pc", mem_pc, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    m_boot = 1; m_fault = 0; m_lat = 1; m_pc = 0; m_count = 0; m_fault_pc = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Reset release: boot, fetch, then bundle at 0.
    step(1, 0, 1, 32'h100);  // redirect ignored in BOOT
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);  // stall at id_pc=4
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h40);  // stall + redirect at id_pc=8
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h42);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 32'h43);  // second misaligned target updates fault_pc
    step(1, 0, 1, 32'h80);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(255) == 0) t = 32'hFFFF_FFF8;
      step(($urandom_range(199) != 0), ($urandom_range(3) == 0), ($urandom_range(11) == 0), t);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
